min_search_ctrl: RTL and testbench

Sequencer and result-register block for the minimum-search datapath. It walks a memory region word by word and drives the comparator's `Load_Min` flag on the first word. It consumes the comparator's `Load_Min_D` and `Load_Addr` flags to update the running minimum value and its address, then signals completion. It sits directly around the comparator: upstream as its control source, downstream as its `Min_Reg` and `Min_Addr` holder.

---
 rtl/min_search_pkg.sv | 14 +
 rtl/min_search_regs.sv | 57 +++++
 rtl/min_search_ctrl.sv | 136 +++++++++++++
 tb/tb_min_search_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/min_search_pkg.sv
// Shared types and default widths for the minimum-search sequencer.
package min_search_pkg;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefAddrW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } min_state_t;

endpackage

// File: rtl/min_search_regs.sv
// Result registers: running minimum value, its address and the result-valid flag.
module min_search_regs import min_search_pkg::*; #(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_valid_i,
    input  logic              data_vld_i,
    input  logic              load_val_i,
    input  logic              load_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic [ADDR_W-1:0] addr_dly_i,
    output logic [DATA_W-1:0] min_reg_o,
    output logic [ADDR_W-1:0] min_addr_o,
    output logic              min_valid_o
);

    logic [DATA_W-1:0] min_reg_d, min_reg_q;
    logic [ADDR_W-1:0] min_addr_d, min_addr_q;
    logic              min_valid_d, min_valid_q;

    // Comparator flags only count while the delayed read strobe marks real data.
    always_comb begin
        min_reg_d   = min_reg_q;
        min_addr_d  = min_addr_q;
        min_valid_d = min_valid_q;
        if (clr_valid_i) begin
            min_valid_d = 1'b0;
        end
        if (data_vld_i && load_val_i) begin
            min_reg_d   = rd_data_i;
            min_valid_d = 1'b1;
        end
        if (data_vld_i && load_addr_i) begin
            min_addr_d  = addr_dly_i;
            min_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            min_reg_q   <= '0;
            min_addr_q  <= '0;
            min_valid_q <= 1'b0;
        end else begin
            min_reg_q   <= min_reg_d;
            min_addr_q  <= min_addr_d;
            min_valid_q <= min_valid_d;
        end
    end

    assign min_reg_o   = min_reg_q;
    assign min_addr_o  = min_addr_q;
    assign min_valid_o = min_valid_q;

endmodule

// File: rtl/min_search_ctrl.sv
// Minimum-search sequencer: walks addresses 0..Length-1 and holds the result.
// Optional MIN_SEARCH_ABORT_EN adds an Abort input that cancels a running search.
module min_search_ctrl import min_search_pkg::*; #(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [ADDR_W:0]   Length,
`ifdef MIN_SEARCH_ABORT_EN
    input  logic              Abort,
`endif
    output logic              Mem_Rd_En,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic [DATA_W-1:0] Read_Data,
    output logic              Load_Min,
    input  logic              Load_Min_D,
    input  logic              Load_Addr,
    output logic [DATA_W-1:0] Min_Reg,
    output logic [ADDR_W-1:0] Min_Addr,
    output logic              Busy,
    output logic              Done,
    output logic              Min_Valid
);

    localparam logic [ADDR_W:0]   MaxLen  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LenOne  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

    min_state_t        state_d, state_q;
    logic [ADDR_W:0]   len_d, len_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [ADDR_W-1:0] addr_dly_d, addr_dly_q;
    logic              data_vld_d, data_vld_q;
    logic              first_d, first_q;
    logic              start_acc;
    logic              last_addr;
    logic              abort_hit;

`ifdef MIN_SEARCH_ABORT_EN
    assign abort_hit = Abort && ((state_q == StRead) || (state_q == StDrain));
`else
    assign abort_hit = 1'b0;
`endif

    assign start_acc = Start && (state_q == StIdle);
    assign last_addr = ({1'b0, addr_q} == (len_q - LenOne));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (Start) state_d = (Length == '0) ? StDone : StRead;
            StRead:  if (last_addr) state_d = StDrain;
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort_hit) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        Mem_Rd_En = (state_q == StRead);
        Mem_Addr  = addr_q;
        Busy      = (state_q != StIdle);
        Done      = (state_q == StDone);
        Load_Min  = data_vld_q && first_q;
    end

    // Counter parks at 0 after the last address so it never wraps past 2^ADDR_W-1.
    always_comb begin
        len_d      = len_q;
        addr_d     = addr_q;
        first_d    = first_q;
        if (start_acc) begin
            len_d   = (Length > MaxLen) ? MaxLen : Length;
            addr_d  = '0;
            first_d = 1'b1;
        end else if (state_q == StRead) begin
            addr_d = last_addr ? '0 : (addr_q + AddrOne);
        end
        if (data_vld_q) begin
            first_d = 1'b0;
        end
        if (abort_hit) begin
            addr_d  = '0;
            first_d = 1'b0;
        end
        data_vld_d = Mem_Rd_En && !abort_hit;
        addr_dly_d = addr_q;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            len_q      <= '0;
            addr_q     <= '0;
            addr_dly_q <= '0;
            data_vld_q <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            len_q      <= len_d;
            addr_q     <= addr_d;
            addr_dly_q <= addr_dly_d;
            data_vld_q <= data_vld_d;
            first_q    <= first_d;
        end
    end

    min_search_regs #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_regs (
        .clk_i       (Clk),
        .rst_i       (Rst),
        .clr_valid_i (start_acc || abort_hit),
        .data_vld_i  (data_vld_q && !abort_hit),
        .load_val_i  (Load_Min_D),
        .load_addr_i (Load_Addr),
        .rd_data_i   (Read_Data),
        .addr_dly_i  (addr_dly_q),
        .min_reg_o   (Min_Reg),
        .min_addr_o  (Min_Addr),
        .min_valid_o (Min_Valid)
    );

endmodule

// File: tb/tb_min_search_ctrl.sv
// Bench for min_search_ctrl: memory + strict less-than comparator around the DUT,
// a timeline model checked every cycle, and literal checks per directed scenario.
module tb_min_search_ctrl;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   length;
    logic          abort_in;
    logic          rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] rd_data;
    logic          load_min;
    logic          ld_d;
    logic          ld_a;
    logic [DW-1:0] min_reg;
    logic [AW-1:0] min_addr;
    logic          busy;
    logic          done;
    logic          min_valid;

    logic [DW-1:0] mem [256];

    int n_cmp  = 0;
    int n_fail = 0;
    int done_seen = 0;

    // Model state
    bit          active;
    int          c;
    int          n;
    int          last;
    int          j;
    logic [DW-1:0] exp_min;
    int          exp_addr;
    bit          exp_valid;
    bit          e_rd;

    always #5 clk = ~clk;

    min_search_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .Clk        (clk),
        .Rst        (rst),
        .Start      (start),
        .Length     (length),
`ifdef MIN_SEARCH_ABORT_EN
        .Abort      (abort_in),
`endif
        .Mem_Rd_En  (rd_en),
        .Mem_Addr   (mem_addr),
        .Read_Data  (rd_data),
        .Load_Min   (load_min),
        .Load_Min_D (ld_d),
        .Load_Addr  (ld_a),
        .Min_Reg    (min_reg),
        .Min_Addr   (min_addr),
        .Busy       (busy),
        .Done       (done),
        .Min_Valid  (min_valid)
    );

    // Memory returns 0 when not read, so comparator flags also fire on invalid cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= rd_en ? mem[mem_addr] : '0;
    end

    assign ld_d = load_min | (rd_data < min_reg);
    assign ld_a = ld_d;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: c is the cycle number since the accepting edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            active = 0; c = 0; n = 0; last = 0;
            exp_min = '0; exp_addr = 0; exp_valid = 0;
        end else if (!active) begin
            if (start) begin
                active    = 1;
                c         = 1;
                n         = (length > 256) ? 256 : int'(length);
                last      = (n == 0) ? 1 : n + 2;
                exp_valid = 0;
            end
        end else if (abort_in && n > 0 && c <= n + 1) begin
            active    = 0;
            exp_valid = 0;
        end else begin
            c++;
            if (c >= 3 && c - 3 < n) begin
                j = c - 3;
                if (j == 0 || mem[j] < exp_min) begin
                    exp_min   = mem[j];
                    exp_addr  = j;
                    exp_valid = 1;
                end
            end
            if (c > last) active = 0;
        end
    end

    always @(negedge clk) begin
        if (done) done_seen++;
        if (!rst) begin
            e_rd = active && n > 0 && c >= 1 && c <= n;
            chk("busy", busy, active);
            chk("done", done, active && c == last);
            chk("rd_en", rd_en, e_rd);
            if (e_rd) chk("mem_addr", mem_addr, c - 1);
            chk("load_min", load_min, active && n > 0 && c == 2);
            chk("min_reg", min_reg, exp_min);
            chk("min_addr", min_addr, exp_addr);
            chk("min_valid", min_valid, exp_valid);
        end
    end

    // Called at posedge+1; returns the cycle (from the accepting edge) Done was seen, 0 on timeout.
    task automatic run(input int len, output int dcyc);
        start  = 1'b1;
        length = len[AW:0];
        @(posedge clk); #1;
        start = 1'b0;
        dcyc  = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (done) begin
                dcyc = k;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    int d;
    int ds;

    initial begin
        rst = 1'b1; start = 1'b0; length = '0; abort_in = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_min_reg", min_reg, 0);
        chk("reset_min_addr", min_addr, 0);
        chk("reset_min_valid", min_valid, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        mem[0] = 16'd9; mem[1] = 16'd3; mem[2] = 16'd7; mem[3] = 16'd3;
        run(4, d);
        chk("t1_done_cycle", d, 6);
        chk("t1_min_reg", min_reg, 3);
        chk("t1_min_addr", min_addr, 1);
        chk("t1_min_valid", min_valid, 1);

        // Back-to-back start in the first idle cycle after Done
        mem[0] = 16'hFFFF;
        run(1, d);
        chk("t2_done_cycle", d, 3);
        chk("t2_min_reg", min_reg, 16'hFFFF);
        chk("t2_min_addr", min_addr, 0);
        chk("t2_min_valid", min_valid, 1);

        run(0, d);
        chk("t3_done_cycle", d, 1);
        chk("t3_min_valid", min_valid, 0);
        chk("t3_min_reg_held", min_reg, 16'hFFFF);

        for (int i = 0; i < 256; i++) mem[i] = 16'(255 - i);
        run(256, d);
        chk("t4_done_cycle", d, 258);
        chk("t4_min_reg", min_reg, 0);
        chk("t4_min_addr", min_addr, 255);
        chk("t4_min_valid", min_valid, 1);

        run(300, d);
        chk("t5_sat_done_cycle", d, 258);
        chk("t5_sat_min_addr", min_addr, 255);

        // Mid-search Start ignored, then asynchronous reset in cycle 3
        mem[0] = 16'd20; mem[1] = 16'd30; mem[2] = 16'd10; mem[3] = 16'd40;
        start = 1'b1; length = 9'd8;
        @(posedge clk); #1;
        start = 1'b1; length = 9'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        chk("t6_busy_before_rst", busy, 1);
        chk("t6_min_reg_before_rst", min_reg, 20);
        chk("t6_addr_before_rst", mem_addr, 2);
        ds = done_seen;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rd_en", rd_en, 0);
        chk("t6_rst_min_reg", min_reg, 0);
        chk("t6_rst_min_addr", min_addr, 0);
        chk("t6_rst_load_min", load_min, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("t6_no_done", done_seen, ds);

`ifdef MIN_SEARCH_ABORT_EN
        mem[0] = 16'd5; mem[1] = 16'd4; mem[2] = 16'd1;
        for (int i = 3; i < 8; i++) mem[i] = 16'd2;
        ds = done_seen;
        start = 1'b1; length = 9'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        abort_in = 1'b1;
        @(posedge clk); #1;
        abort_in = 1'b0;
        chk("t7_abort_busy", busy, 0);
        chk("t7_abort_min_valid", min_valid, 0);
        chk("t7_abort_min_reg", min_reg, 4);
        chk("t7_abort_min_addr", min_addr, 1);
        repeat (12) @(posedge clk);
        #1;
        chk("t7_abort_no_done", done_seen, ds);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
